down_counter: RTL and testbench

Loadable N-bit down-counter/timer, the counting-down counterpart to the free-running up counter. Software or an upstream FSM loads a count, starts it, and receives a single-cycle terminal-count pulse when the count reaches zero. Intended as a programmable delay/interval timer in the same designs that use the up counter for event counting.

---
 rtl/counter_pkg.sv | 17 +
 rtl/down_counter_if.sv | 33 +++
 rtl/down_counter.sv | 133 +++++++++++++
 tb/tb_down_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: definitions shared by the up counter and the down counter.
//   COUNTER_WIDTH_DEFAULT : default counter width in bits for both counters
//   ST_IDLE / ST_RUN      : state encoding of the down counter
//   state_e               : enumerated state type built from that encoding
package counter_pkg;

  localparam int COUNTER_WIDTH_DEFAULT = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_e;

endpackage

// File: rtl/down_counter_if.sv
// down_counter_if: control and status bundle of the down counter.
//   load, load_val    : load a new count (and reload value)
//   start, stop       : start / abort counting
//   pause             : freeze the count while running
//   Q, busy, tc       : current count, running flag, terminal-count pulse
// Modports: master drives the controls (software / upstream FSM),
//           slave is the counter itself.
interface down_counter_if
  import counter_pkg::*;
#(
  parameter int n = COUNTER_WIDTH_DEFAULT
);

  logic         load;
  logic [n-1:0] load_val;
  logic         start;
  logic         stop;
  logic         pause;
  logic [n-1:0] Q;
  logic         busy;
  logic         tc;

  modport master (
    output load, load_val, start, stop, pause,
    input  Q, busy, tc
  );

  modport slave (
    input  load, load_val, start, stop, pause,
    output Q, busy, tc
  );

endinterface

// File: rtl/down_counter.sv
// down_counter: loadable n-bit down counter / interval timer.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : down_counter_if.slave (load/load_val/start/stop/pause in,
//           Q/busy/tc out)
// Input priority: reset > stop > load > start > pause.
// tc is a registered single-cycle pulse issued when the count ends.
// Build option DOWN_COUNTER_AUTO_RELOAD_EN: when defined the counter reloads
// from its reload register after reaching zero and keeps running; when not
// defined it is a one-shot timer and the reload register does not exist.
module down_counter
  import counter_pkg::*;
#(
  parameter int n = COUNTER_WIDTH_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  down_counter_if.slave  bus
);

  localparam logic [n-1:0] ZERO = {n{1'b0}};
  localparam logic [n-1:0] ONE  = {{(n-1){1'b0}}, 1'b1};

  state_e       state_r;
  state_e       state_s;
  logic [n-1:0] q_r;
  logic [n-1:0] q_s;
  logic [n-1:0] start_q_s;
  logic         tc_r;
  logic         tc_s;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [n-1:0] reload_r;
  logic [n-1:0] reload_s;
`endif

  // Next-state, next-count and terminal-count decision.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    tc_s    = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_s = reload_r;
`endif
    // Count a start would begin from: a simultaneous load wins over Q.
    start_q_s = bus.load ? bus.load_val : q_r;

    case (state_r)
      IDLE: begin
        // stop and pause are meaningless while idle.
        if (bus.load) begin
          q_s = bus.load_val;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          reload_s = bus.load_val;
`endif
        end else begin
          q_s = q_r;
        end
        if (bus.start) begin
          // Starting from zero ends immediately: pulse tc, stay idle.
          if (start_q_s == ZERO) begin
            tc_s = 1'b1;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_s = IDLE;
        end else if (bus.load) begin
          // A load while running replaces the count; no decrement this edge.
          q_s = bus.load_val;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          reload_s = bus.load_val;
`endif
        end else if (bus.pause) begin
          q_s = q_r;
        end else if (q_r > ONE) begin
          q_s = q_r - ONE;
        end else if (q_r == ONE) begin
          q_s  = ZERO;
          tc_s = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          state_s = RUN;
`else
          state_s = IDLE;
`endif
        end else begin
          // Q is zero while running: reached only by loading 0, or by the
          // one-cycle zero hold of reload mode.
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          q_s = reload_r;
`else
          tc_s    = 1'b1;
          state_s = IDLE;
`endif
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, count, reload and tc registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      q_r      <= ZERO;
      tc_r     <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_r <= ZERO;
`endif
    end else begin
      state_r  <= state_s;
      q_r      <= q_s;
      tc_r     <= tc_s;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_r <= reload_s;
`endif
    end
  end

  assign bus.Q    = q_r;
  assign bus.busy = (state_r == RUN);
  assign bus.tc   = tc_r;

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed self-checking bench for down_counter (n = 4).
// Each comparison checks the packed status {Q, busy, tc} one time unit after
// a rising clock edge against a hand-computed expectation.
module tb_down_counter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [5:0] exp;
  logic [5:0] got;

  down_counter_if #(.n(4)) bus ();

  down_counter #(.n(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Drive one cycle of inputs, let the edge sample them, then clear them.
  task automatic step(input logic ld, input logic [3:0] lv, input logic st,
                      input logic sp, input logic ps);
    bus.load     = ld;
    bus.load_val = lv;
    bus.start    = st;
    bus.stop     = sp;
    bus.pause    = ps;
    @(posedge clk);
    #1;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd0, 1'b0, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_state got {Q,busy,tc}=%h expected %h", got, exp); end
    // Reset while running at Q = 5.
    step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd5, 1'b1, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_prerun got {Q,busy,tc}=%h expected %h", got, exp); end
    reset = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd0, 1'b0, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_in_run got {Q,busy,tc}=%h expected %h", got, exp); end
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd0, 1'b0, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_no_tc got {Q,busy,tc}=%h expected %h", got, exp); end
  endtask

  task automatic test_count5;
    step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd5, 1'b0, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL count5_load got {Q,busy,tc}=%h expected %h", got, exp); end
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd5, 1'b1, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL count5_start got {Q,busy,tc}=%h expected %h", got, exp); end
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      got = {bus.Q, bus.busy, bus.tc};
      exp = {(i < 5) ? 4'(5 - i) : 4'd0, (i < 5), (i == 5)};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL count5[%0d] got {Q,busy,tc}=%h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_pause;
    logic [3:0] q_tab [5];
    logic       p_tab [5];
    q_tab = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
    p_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd3, 1'b1, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL pause_start got {Q,busy,tc}=%h expected %h", got, exp); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, p_tab[i]);
      got = {bus.Q, bus.busy, bus.tc};
      exp = {q_tab[i], (i < 4), (i == 4)};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL pause[%0d] got {Q,busy,tc}=%h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_stop_resume;
    step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd6, 1'b1, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL stop_pre got {Q,busy,tc}=%h expected %h", got, exp); end
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd6, 1'b0, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL stop_hold got {Q,busy,tc}=%h expected %h", got, exp); end
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd6, 1'b0, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL stop_idle got {Q,busy,tc}=%h expected %h", got, exp); end
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      got = {bus.Q, bus.busy, bus.tc};
      exp = {4'(6 - i), (i < 6), (i == 6)};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL resume[%0d] got {Q,busy,tc}=%h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_start_zero;
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd0, 1'b0, 1'b1}; checks++;
    if (got !== exp) begin failures++; $display("FAIL zero_start got {Q,busy,tc}=%h expected %h", got, exp); end
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd0, 1'b0, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL zero_after got {Q,busy,tc}=%h expected %h", got, exp); end
    step(1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd15, 1'b1, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL load_start15 got {Q,busy,tc}=%h expected %h", got, exp); end
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      got = {bus.Q, bus.busy, bus.tc};
      exp = {4'(15 - i), (i < 15), (i == 15)};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL count15[%0d] got {Q,busy,tc}=%h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_load_in_run;
    step(1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd4, 1'b1, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL run_load got {Q,busy,tc}=%h expected %h", got, exp); end
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd3, 1'b1, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL run_load_dec got {Q,busy,tc}=%h expected %h", got, exp); end
    // stop outranks load: Q holds, counter idles.
    step(1'b1, 4'd10, 1'b0, 1'b1, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd3, 1'b0, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL stop_over_load got {Q,busy,tc}=%h expected %h", got, exp); end
  endtask

  task automatic test_reload;
    step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      got = {bus.Q, bus.busy, bus.tc};
      exp = {4'(2 - (i % 3)), 1'b1, ((i % 3) == 2)};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL reload2[%0d] got {Q,busy,tc}=%h expected %h", i, got, exp); end
    end
    step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd4, 1'b1, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL reload_load4 got {Q,busy,tc}=%h expected %h", got, exp); end
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      got = {bus.Q, bus.busy, bus.tc};
      exp = {4'(4 - (i % 5)), 1'b1, ((i % 5) == 4)};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL reload4[%0d] got {Q,busy,tc}=%h expected %h", i, got, exp); end
    end
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    got = {bus.Q, bus.busy, bus.tc}; exp = {4'd4, 1'b0, 1'b0}; checks++;
    if (got !== exp) begin failures++; $display("FAIL reload_stop got {Q,busy,tc}=%h expected %h", got, exp); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    @(negedge clk);
    test_reset();
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    test_reload();
`else
    test_count5();
    test_pause();
    test_stop_resume();
    test_start_zero();
    test_load_in_run();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
